// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   state_t : responder FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   CNT_W   : width of the wait-state down-counter
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x 32 storage with a single shared address.
// Writes and reads are both synchronous. Each set bit of be writes one byte lane.
// The read register holds its value while re is low.
// Ports:
//   clk   : clock
//   we    : write enable
//   re    : read enable (loads rdata on the edge)
//   be    : byte-lane enables; bit i covers wdata[8i+7:8i]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage has no reset; a reset port on a RAM blocks RAM inference,
    // and the contents are undefined until software writes them.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding data-memory responder with a valid/ready request channel
// and a valid/ready response channel. The access latency is WAIT_STATES + 1
// cycles.
// Misaligned or out-of-range accesses respond with rsp_err=1 and do not touch
// storage.
// Optional feature: define DMEM_BYTE_EN_EN so that stores honour req_be.
// Without it, every store writes the full word.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   req_valid / req_ready  : request handshake (ready only in IDLE)
//   req_write              : 1 = store, 0 = load
//   req_addr               : byte address
//   req_wdata              : store data
//   req_be                 : store byte enables
//   rsp_valid / rsp_ready  : response handshake (valid only in RESP)
//   rsp_rdata              : load data (0 for stores and errors)
//   rsp_err                : access rejected
// -----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        be_q;
    logic              err_q, rd_ok_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_write, cur_err;
    logic [31:0]       cur_addr, cur_wdata;
    logic [3:0]        cur_be, wr_be;
    logic [31:0]       arr_rdata;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // With WAIT_STATES=0 the edge entering RESP is the acceptance edge.
    // The request registers are not loaded yet at that edge, so the live
    // request is used in IDLE.
    assign cur_write = (state == IDLE) ? req_write : wr_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_be    = (state == IDLE) ? req_be    : be_q;

    assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);

`ifdef DMEM_BYTE_EN_EN
    assign wr_be = cur_be;
`else
    // Byte enables are ignored here: the OR forces every store to the full word.
    assign wr_be = cur_be | 4'hF;
`endif

    assign enter_resp = (state_nxt == RESP) && (state != RESP);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)       state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT: if (cnt == '0)    state_nxt = RESP;
            RESP: if (rsp_ready)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt     <= CNT_INIT;
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_resp) begin
                err_q   <= cur_err;
                rd_ok_q <= !cur_write && !cur_err;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (enter_resp && cur_write && !cur_err),
        .re    (enter_resp && !cur_write && !cur_err),
        .be    (wr_be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    // The array read register is not reset, so it is masked outside a good load.
    assign rsp_rdata = (state == RESP && rd_ok_q) ? arr_rdata : 32'h0;
    assign rsp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed self-checking bench for data_mem_responder.
// The DUT runs with DEPTH=256 and WAIT_STATES=2.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH       (256),
        .WAIT_STATES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // One complete transaction.
    // Checks the handshake and the latency (3 cycles for WAIT_STATES=2).
    // Returns the response data and error flag to the caller.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input string name,
                          output logic [31:0] rdata, output logic err);
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before_accept got %b want 1", name, req_ready);
        end
        @(posedge clk); #1;
        // Scramble the request inputs while busy; the DUT must ignore them.
        req_valid = 1'b0; req_write = ~wr; req_addr = addr ^ 32'h0000_0044;
        req_wdata = ~wdata; req_be = ~be;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL %s ready_after_accept got %b want 0", name, req_ready);
        end
        lat = 1;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
            lat++;
            if (lat > 20) break;
        end
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL %s latency got %0d want 3", name, lat);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL %s release got valid=%b ready=%b want 0/1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] d; logic e;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "store_10", d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL store_10_rsp got d=%h e=%b want 0/0", d, e);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, "load_10", d, e);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("FAIL load_10_rsp got d=%h e=%b want deadbeef/0", d, e);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] d; logic e;
        do_req(1'b0, 32'h13, 32'h0, 4'h0, "load_13", d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL load_13_rsp got d=%h e=%b want 0/1", d, e);
        end
        do_req(1'b1, 32'h12, 32'h12345678, 4'hF, "store_12", d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL store_12_rsp got d=%h e=%b want 0/1", d, e);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, "reload_10", d, e);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("FAIL reload_10_rsp got d=%h e=%b want deadbeef/0", d, e);
        end
    endtask

    task automatic test_range();
        logic [31:0] d; logic e;
        // 0x400 aliases word 0 if the range check were missing.
        do_req(1'b1, 32'h0, 32'h0BADF00D, 4'hF, "store_0", d, e);
        do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, "store_400", d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL store_400_rsp got d=%h e=%b want 0/1", d, e);
        end
        do_req(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, "store_3fc", d, e);
        do_req(1'b0, 32'h3FC, 32'h0, 4'h0, "load_3fc", d, e);
        checks++;
        if (d !== 32'hCAFEF00D || e !== 1'b0) begin
            errors++; $display("FAIL load_3fc_rsp got d=%h e=%b want cafef00d/0", d, e);
        end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, "load_0", d, e);
        checks++;
        if (d !== 32'h0BADF00D || e !== 1'b0) begin
            errors++; $display("FAIL load_0_rsp got d=%h e=%b want 0badf00d/0", d, e);
        end
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'h0;
        @(posedge clk); #1;
        // Keep presenting a store while busy; it must not be taken.
        req_write = 1'b1; req_wdata = 32'h0;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1 || n > 20) break;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d got v=%b d=%h e=%b rdy=%b want 1/deadbeef/0/0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d; logic e;
        do_req(1'b1, 32'h30, 32'h11223344, 4'hF, "be_init", d, e);
        do_req(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, "be_store", d, e);
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("FAIL be_store_err got %b want 0", e);
        end
        do_req(1'b0, 32'h30, 32'h0, 4'h0, "be_load", d, e);
        checks++;
`ifdef DMEM_BYTE_EN_EN
        if (d !== 32'h11BB33DD) begin
            errors++; $display("FAIL be_load got %h want 11bb33dd", d);
        end
        do_req(1'b1, 32'h30, 32'h99999999, 4'b0000, "be_none", d, e);
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("FAIL be_none_err got %b want 0", e);
        end
        do_req(1'b0, 32'h30, 32'h0, 4'h0, "be_none_load", d, e);
        checks++;
        if (d !== 32'h11BB33DD) begin
            errors++; $display("FAIL be_none_load got %h want 11bb33dd", d);
        end
`else
        if (d !== 32'hAABBCCDD) begin
            errors++; $display("FAIL be_load got %h want aabbccdd", d);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] d; logic e;
        int seen;
        do_req(1'b1, 32'h20, 32'h00000011, 4'hF, "pre_store_20", d, e);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        // The FSM is in WAIT here.
        reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL midreset_outputs got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midreset_no_rsp got %0d valid cycles want 0", seen);
        end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, "post_reset_load_20", d, e);
        checks++;
        if (d !== 32'h00000011 || e !== 1'b0) begin
            errors++; $display("FAIL midreset_word20 got d=%h e=%b want 00000011/0", d, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e;
        do_req(1'b1, 32'h40, 32'h01020304, 4'hF, "b2b_store", d, e);
        do_req(1'b0, 32'h40, 32'h0, 4'h0, "b2b_load", d, e);
        checks++;
        if (d !== 32'h01020304 || e !== 1'b0) begin
            errors++; $display("FAIL b2b_load got d=%h e=%b want 01020304/0", d, e);
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_misaligned();
        test_range();
        test_stall();
        test_byte_enable();
        test_reset_mid_access();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256: number of 32-bit words stored, a power of two from 16 to 4096.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2: added access latency in cycles, 0 to 15.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1: the responder accepts a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32: store data.
REQ-010 The block SHALL have port req_be, input, 4: store byte enables; bit i covers bits 8i+7..8i.
REQ-011 The block SHALL have port rsp_valid, output, 1: response available.
REQ-012 The block SHALL have port rsp_ready, input, 1: the initiator takes the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32: load data; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1: the access was rejected.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; at acceptance the block SHALL register req_write, req_addr, req_wdata and req_be.
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 rsp_valid SHALL be 1 only in RESP.
REQ-019 From IDLE on acceptance, the FSM SHALL go to WAIT if WAIT_STATES > 0, otherwise straight to RESP.
REQ-020 In WAIT, a 4-bit counter SHALL load WAIT_STATES-1 at acceptance and decrement every cycle; the FSM SHALL move to RESP on the edge where the counter equals 0.
REQ-021 The access latency SHALL be WAIT_STATES+1 cycles, from the acceptance edge to the first cycle with rsp_valid=1.
REQ-022 The FSM SHALL stay in RESP, with rsp_rdata and rsp_err stable, until rsp_ready=1, then return to IDLE.
REQ-023 A new request SHALL be accepted no earlier than the cycle after the RESP-to-IDLE edge; there SHALL be no back-to-back overlap.
REQ-024 Word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-025 The block SHALL raise rsp_err=1 if req_addr[1:0] != 0 (misaligned) or if req_addr >= 4*DEPTH (out of range).
REQ-026 An errored request SHALL not modify storage and SHALL return rsp_rdata=0.
REQ-027 A store SHALL commit to storage on the edge entering RESP; in RESP it SHALL return rsp_rdata=0 and rsp_err=0.
REQ-028 A load SHALL read storage on the edge entering RESP and return that word in rsp_rdata.
REQ-029 A load that follows a store to the same word SHALL return the stored data.
REQ-030 Request input changes while not in IDLE SHALL be ignored.

Reset
REQ-031 Asserting reset_n=0 at any time, including mid-access, SHALL immediately force IDLE and the counter to 0.
REQ-032 On reset, outputs SHALL be rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready SHALL be 1 one edge after reset_n rises.
REQ-033 A store still in WAIT when reset asserts SHALL be discarded.
REQ-034 Storage contents SHALL not be reset and are undefined until written.

Configuration
REQ-035 With DMEM_BYTE_EN_EN defined, a store SHALL write only the bytes whose req_be bit is 1; req_be=0000 SHALL write nothing and respond without error.
REQ-036 Without DMEM_BYTE_EN_EN, req_be SHALL be ignored and every store SHALL write the full word.

Structure
REQ-037 The FSM state encoding (IDLE=0, WAIT=1, RESP=2) and the counter width constant (4) SHALL live in shared package dmem_pkg.
REQ-038 Storage SHALL be the sub-module dmem_array: a DEPTH x 32 synchronous-write, synchronous-read array with byte enables.

Verification
REQ-039 The bench SHALL cover: WAIT_STATES=2; store 0xDEADBEEF at 0x10 then load 0x10 -> rsp_valid exactly 3 cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-040 The bench SHALL cover: load at 0x13 -> err=1, rdata=0; a following store at 0x12 -> err=1 and the word at 0x10 is unchanged.
REQ-041 The bench SHALL cover: DEPTH=256, store at 0x400 -> err=1; load at 0x3FC -> err=0.
REQ-042 The bench SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and data stable and req_ready=0 throughout; IDLE on the edge after rsp_ready=1.
REQ-043 The bench SHALL cover: with DMEM_BYTE_EN_EN defined, word 0x11223344 then store 0xAABBCCDD with be=0101 -> load returns 0x11BB33DD; without the macro -> 0xAABBCCDD.
REQ-044 The bench SHALL cover: reset_n pulsed low during WAIT of a store of 0x55 to 0x20 -> rsp_valid=0 at once, no response issued, word at 0x20 keeps its prior value.
